accum_cpu: RTL

ACCUM_CPU -- requirements
Module: accum_cpu

---
 rtl/accum_cpu_if.sv | 22 ++
 rtl/accum_cpu.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/accum_cpu_if.sv
// Flash read port of accum_cpu: word request out, data and ready back.
// master = CPU side, slave = flash controller side.
interface accum_cpu_if;
    logic [23:0] flashReadAddr;
    logic        flashEnabled;
    logic [15:0] flashByteRead;
    logic        flashDataReady;

    modport master (
        output flashReadAddr,
        output flashEnabled,
        input  flashByteRead,
        input  flashDataReady
    );

    modport slave (
        input  flashReadAddr,
        input  flashEnabled,
        output flashByteRead,
        output flashDataReady
    );
endinterface

// File: rtl/accum_cpu.sv
// Accumulator CPU executing 16-bit instruction words fetched over accum_cpu_if.
// Define ACCUM_CPU_STACK_EN to build the CALL/RET return stack and fault flag.
//
// state  | meaning
// FETCH  | issue instruction read at pc
// F_LOW  | wait for controller to drop ready
// F_HIGH | wait for ready, capture instruction
// DECODE | pc += 2, choose immediate or execute
// IMM    | issue immediate read at pc
// I_LOW  | wait for controller to drop ready
// I_HIGH | wait for ready, capture immediate, pc += 2
// EXEC   | apply opcode
// WAIT   | down-count op * WAIT_TICKS cycles
// HALT   | terminal until reset
module accum_cpu #(
    parameter int DATA_W      = 10,
    parameter int NREGS       = 4,
    parameter int PC_W        = 11,
    parameter int WAIT_TICKS  = 27000,
    parameter int STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    accum_cpu_if.master        flash,
    input  logic [3:0]         btn,
    output logic [5:0]         leds,
    output logic               halted,
    output logic               fault
);
    localparam int IDX_W = $clog2(NREGS);
    localparam int CNT_W = DATA_W + $clog2(WAIT_TICKS + 1);

    localparam logic [5:0] OP_CLR  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_STA  = 6'd3;
    localparam logic [5:0] OP_LDA  = 6'd4;
    localparam logic [5:0] OP_INV  = 6'd5;
    localparam logic [5:0] OP_JMPZ = 6'd6;
    localparam logic [5:0] OP_JMP  = 6'd7;
    localparam logic [5:0] OP_WAIT = 6'd8;
    localparam logic [5:0] OP_OUT  = 6'd9;
    localparam logic [5:0] OP_BTN  = 6'd10;
    localparam logic [5:0] OP_CALL = 6'd11;
    localparam logic [5:0] OP_RET  = 6'd12;
    localparam logic [5:0] OP_HLT  = 6'd63;

    typedef enum logic [3:0] {
        FETCH, F_LOW, F_HIGH, DECODE, IMM, I_LOW, I_HIGH, EXEC, WAIT, HALT
    } state_t;

    state_t              state;
    logic [PC_W-1:0]     pc;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   regs [NREGS];
    logic [15:0]         instr;
    logic [DATA_W-1:0]   imm;
    logic [CNT_W-1:0]    wait_cnt;

    logic [5:0]          opcode;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   op;
    logic [PC_W-1:0]     jump_tgt;
    logic [CNT_W-1:0]    wait_load;
    logic                btn_bit;
    logic                unused_bits;

    assign opcode      = instr[14:9];
    assign idx         = instr[IDX_W-1:0];
    assign op          = instr[15] ? imm : regs[idx];
    assign jump_tgt    = PC_W'(op) & ~PC_W'(1);
    assign wait_load   = CNT_W'(op) * CNT_W'(WAIT_TICKS);
    assign btn_bit     = btn[2'(idx)];
    assign unused_bits = ^{instr, flash.flashByteRead};

`ifdef ACCUM_CPU_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    logic [PC_W-1:0] stack [STACK_DEPTH];
    logic [SP_W-1:0] sp;
    logic [SP_W-1:0] sp_dec;
    logic            fault_q;
    assign sp_dec = sp - SP_W'(1);
    assign fault  = fault_q;
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= FETCH;
            pc                  <= '0;
            acc                 <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            instr               <= '0;
            imm                 <= '0;
            wait_cnt            <= '0;
            flash.flashEnabled  <= 1'b0;
            flash.flashReadAddr <= '0;
            leds                <= 6'h3F;
            halted              <= 1'b0;
`ifdef ACCUM_CPU_STACK_EN
            sp                  <= '0;
            fault_q             <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
`endif
        end else begin
            case (state)
                FETCH, IMM: begin
                    flash.flashReadAddr <= 24'(pc);
                    flash.flashEnabled  <= 1'b1;
                    state               <= (state == FETCH) ? F_LOW : I_LOW;
                end
                F_LOW:  if (!flash.flashDataReady) state <= F_HIGH;
                I_LOW:  if (!flash.flashDataReady) state <= I_HIGH;
                F_HIGH: if (flash.flashDataReady) begin
                    instr              <= flash.flashByteRead;
                    flash.flashEnabled <= 1'b0;
                    state              <= DECODE;
                end
                I_HIGH: if (flash.flashDataReady) begin
                    imm                <= DATA_W'(flash.flashByteRead);
                    flash.flashEnabled <= 1'b0;
                    pc                 <= pc + PC_W'(2);
                    state              <= EXEC;
                end
                DECODE: begin
                    pc    <= pc + PC_W'(2);
                    state <= instr[15] ? IMM : EXEC;
                end
                EXEC: begin
                    state <= FETCH;
                    case (opcode)
                        OP_CLR:  acc <= '0;
                        OP_ADD:  acc <= acc + op;
                        OP_SUB:  acc <= acc - op;
                        OP_STA:  regs[idx] <= acc;
                        OP_LDA:  acc <= op;
                        OP_INV:  acc <= ~acc;
                        OP_JMPZ: if (acc == '0) pc <= jump_tgt;
                        OP_JMP:  pc <= jump_tgt;
                        OP_WAIT: if (op != '0) begin
                            wait_cnt <= wait_load - CNT_W'(1);
                            state    <= WAIT;
                        end
                        OP_OUT:  leds <= ~6'(acc);
                        OP_BTN:  acc <= btn_bit ? '0 : DATA_W'(acc != '0);
`ifdef ACCUM_CPU_STACK_EN
                        // Stack errors halt with pc and stack left untouched.
                        OP_CALL: if (sp == SP_W'(STACK_DEPTH)) begin
                            fault_q <= 1'b1;
                            halted  <= 1'b1;
                            state   <= HALT;
                        end else begin
                            stack[PTR_W'(sp)] <= pc;
                            sp                <= sp + SP_W'(1);
                            pc                <= jump_tgt;
                        end
                        OP_RET:  if (sp == '0) begin
                            fault_q <= 1'b1;
                            halted  <= 1'b1;
                            state   <= HALT;
                        end else begin
                            pc <= stack[PTR_W'(sp_dec)];
                            sp <= sp_dec;
                        end
`endif
                        OP_HLT: begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end
                        default: ;
                    endcase
                end
                WAIT: begin
                    if (wait_cnt == '0) state <= FETCH;
                    else wait_cnt <= wait_cnt - CNT_W'(1);
                end
                HALT: flash.flashEnabled <= 1'b0;
                default: state <= FETCH;
            endcase
        end
    end
endmodule
